// File: rtl/final_soc_spis_pkg.sv
// Shared constants and types for the final_soc_spis SPI slave peripheral.
package final_soc_spis_pkg;

  localparam int unsigned DATABITS = 8;
  localparam int unsigned REG_W    = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CNT_W    = $clog2(DATABITS);
  localparam int unsigned LEVEL_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_RXDATA  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TXDATA  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd3;

  localparam int unsigned BIT_ROE   = 3;
  localparam int unsigned BIT_TOE   = 4;
  localparam int unsigned BIT_TUR   = 5;
  localparam int unsigned BIT_TRDY  = 6;
  localparam int unsigned BIT_RRDY  = 7;
  localparam int unsigned BIT_E     = 8;
  localparam int unsigned BIT_SSA   = 9;
  localparam int unsigned LEVEL_LSB = 12;

  // Interrupt-capable flags occupy status[8:3]; enables sit at the same bits.
  localparam int unsigned IRQ_LSB = 3;
  localparam int unsigned IRQ_MSB = 8;
  localparam logic [REG_W-1:0] CTRL_MASK = 16'h01F8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Fill level reported in the status word, clamped to the 3-bit field.
  function automatic logic [LEVEL_W-1:0] sat_level(input logic [7:0] n);
    return (n > 8'd7) ? 3'd7 : n[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/final_soc_spis_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, reset to RESET_VAL.
module final_soc_spis_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/final_soc_spis.sv
// SPI slave (mode 0, MSB first, 8 bits) with a 16-bit CPU register port.
// Define SPIS_RX_FIFO_EN to replace the rx holding register with a FIFO.
module final_soc_spis
  import final_soc_spis_pkg::*;
#(
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_select,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [REG_W-1:0]  data_from_cpu,
  output logic [REG_W-1:0]  data_to_cpu,
  output logic              irq,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic              MISO_oe
);

  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 32'd0) begin : g_depth_check
    $error("RX_FIFO_DEPTH must be a power of 2 and at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATABITS - 1);

  // Pin conditioning and edge detection
  logic sclk_s, mosi_s, ss_n_s;
  logic sclk_d, ss_n_d;

  final_soc_spis_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(SCLK), .q(sclk_s));
  final_soc_spis_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(MOSI), .q(mosi_s));
  final_soc_spis_sync #(.RESET_VAL(1'b1)) u_sync_ss_n (
    .clk(clk), .reset_n(reset_n), .d(SS_n), .q(ss_n_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d <= 1'b0;
      ss_n_d <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ss_n_d <= ss_n_s;
    end
  end

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_n_s & ss_n_d;
  assign ss_rise   = ss_n_s & ~ss_n_d;

  // CPU access strobes: one pulse per held read_n/write_n access
  logic rd_strobe, wr_strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      rd_strobe <= spi_select & ~read_n & ~rd_strobe;
      wr_strobe <= spi_select & ~write_n & ~wr_strobe;
    end
  end

  logic rd_rx, wr_tx, wr_status, wr_ctrl;
  assign rd_rx     = rd_strobe & (mem_addr == ADDR_RXDATA);
  assign wr_tx     = wr_strobe & (mem_addr == ADDR_TXDATA);
  assign wr_status = wr_strobe & (mem_addr == ADDR_STATUS);
  assign wr_ctrl   = wr_strobe & (mem_addr == ADDR_CONTROL);

  // Serial engine state
  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATABITS-2:0]   rx_shift;
  logic [DATABITS-1:0]   tx_shift;
  logic                  reload_pending;

  logic [DATABITS-1:0]   tx_holding;
  logic                  tx_primed;

  logic                  tx_load, byte_done;
  logic [DATABITS-1:0]   rx_byte, tx_load_val;

  assign rx_byte     = {rx_shift, mosi_s};
  assign tx_load_val = tx_primed ? tx_holding : '0;
  assign tx_load     = ((state == IDLE) & ss_fall) |
                       ((state == ACTIVE) & ~ss_rise & sclk_fall & reload_pending);
  assign byte_done   = (state == ACTIVE) & ~ss_rise & sclk_rise & (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      reload_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state          <= ACTIVE;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
            tx_shift       <= tx_load_val;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state          <= IDLE;
            reload_pending <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_byte[DATABITS-2:0];
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) reload_pending <= 1'b1;
            end
            // After a full byte the next falling edge presents a fresh byte
            if (sclk_fall) begin
              if (reload_pending) begin
                tx_shift       <= tx_load_val;
                reload_pending <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO    = tx_shift[DATABITS-1];
  assign MISO_oe = ~SS_n;

  // Receive storage
  logic                 rrdy;
  logic                 rx_overrun;
  logic [DATABITS-1:0]  rx_rd_data;
  logic [LEVEL_W-1:0]   level;

`ifdef SPIS_RX_FIFO_EN
  localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);

  logic [DATABITS-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         fill;
  logic                fifo_full, push, pop;

  assign fifo_full  = (fill == (AW+1)'(RX_FIFO_DEPTH));
  assign pop        = rd_rx & (fill != '0);
  assign push       = byte_done & (~fifo_full | pop);
  assign rx_overrun = byte_done & fifo_full & ~pop;
  assign rrdy       = (fill != '0);
  assign rx_rd_data = fifo_mem[rd_ptr];
  assign level      = sat_level(8'(fill));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end
`else
  logic [DATABITS-1:0] rx_holding;

  // A read in the same cycle as a new byte is not an overrun
  assign rx_overrun = byte_done & rrdy & ~rd_rx;
  assign rx_rd_data = rx_holding;
  assign level      = '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_holding <= '0;
      rrdy       <= 1'b0;
    end else begin
      if (rd_rx) rrdy <= 1'b0;
      if (byte_done) begin
        rx_holding <= rx_byte;
        rrdy       <= 1'b1;
      end
    end
  end
`endif

  // Status word assembly
  logic roe, toe, tur;
  logic [REG_W-1:0] control;
  logic [REG_W-1:0] status_word;

  always_comb begin
    status_word                      = '0;
    status_word[BIT_ROE]             = roe;
    status_word[BIT_TOE]             = toe;
    status_word[BIT_TUR]             = tur;
    status_word[BIT_TRDY]            = ~tx_primed;
    status_word[BIT_RRDY]            = rrdy;
    status_word[BIT_E]               = roe | toe | tur;
    status_word[BIT_SSA]             = ~ss_n_s;
    status_word[LEVEL_LSB +: LEVEL_W] = level;
  end

  // CPU-visible registers, flags, read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_holding  <= '0;
      tx_primed   <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tur         <= 1'b0;
      control     <= '0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_status) begin
        roe <= 1'b0;
        toe <= 1'b0;
        tur <= 1'b0;
      end
      if (wr_ctrl) control <= data_from_cpu & CTRL_MASK;
      if (tx_load) begin
        tx_primed <= 1'b0;
        if (!tx_primed) tur <= 1'b1;
      end
      // Judged against the pre-load tx_primed value
      if (wr_tx) begin
        if (tx_primed) begin
          toe <= 1'b1;
        end else begin
          tx_holding <= data_from_cpu[DATABITS-1:0];
          tx_primed  <= 1'b1;
        end
      end
      if (rx_overrun) roe <= 1'b1;
      if (rd_strobe) begin
        case (mem_addr)
          ADDR_RXDATA:  data_to_cpu <= {{(REG_W-DATABITS){1'b0}}, rx_rd_data};
          ADDR_STATUS:  data_to_cpu <= status_word;
          ADDR_CONTROL: data_to_cpu <= control;
          default:      data_to_cpu <= '0;
        endcase
      end
      irq <= |(status_word[IRQ_MSB:IRQ_LSB] & control[IRQ_MSB:IRQ_LSB]);
    end
  end

endmodule

// File: doc/final_soc_spis.md
# final_soc_spis

SPI slave peripheral: the receiving end of the SoC's SPI master. An external SPI master (MCU, second FPGA, test jig) can exchange 8-bit frames with the Nios CPU through it. The CPU side is a 16-bit memory-mapped register port with the same two-cycle access style as the SoC's SPI master. The SPI side is fixed to mode 0 (CPOL=0, CPHA=0), MSB first, 8 data bits.

## Interface
- RX_FIFO_DEPTH, 4: receive FIFO depth; used only when the FIFO feature is compiled in; power of 2.
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous reset, active-low
- spi_select  in  1  register-port chip select
- mem_addr  in  3  register address: 0 rxdata (r), 1 txdata (w), 2 status (r; any write clears flags), 3 control (r/w)
- read_n, write_n  in  1  active-low strobes
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  registered read data
- irq  out  1  registered interrupt
- SCLK, MOSI, SS_n  in  1  asynchronous SPI pins
- MISO  out  1  serial data out
- MISO_oe  out  1  tri-state enable, equal to ~SS_n (raw, combinational)

## Operation
- **CPU access strobes.** rd_strobe/wr_strobe pulse exactly once per access. Condition: spi_select & ~read_n (or ~write_n) while the strobe register is 0.
- **Status word:** [3] ROE, [4] TOE, [5] TUR, [6] TRDY, [7] RRDY, [8] E = ROE|TOE|TUR, [9] SSA (synchronized SS_n low). Other bits read 0.
- **Control word:** irq enables at the same bit positions [3..8]. Other bits read 0.
- **irq** = OR of each status flag [3..8] ANDed with its enable, registered.
- **TX path.**
  - TRDY = ~tx_primed.
  - txdata write with TRDY=1: tx_holding <= data[7:0], tx_primed <= 1.
  - txdata write with TRDY=0: data dropped, TOE <= 1.
- **Input conditioning.** SCLK, MOSI and SS_n each pass through a 2-flop synchronizer. Edge detect uses the synchronized SCLK against its delayed copy.
- **FSM IDLE.**
  - Reset state.
  - Synchronized SS_n falling edge: go to ACTIVE, bit_cnt <= 0, load tx shifter.
- **FSM ACTIVE.**
  - SCLK rise: rx_shift <= {rx_shift[6:0], MOSI}, bit_cnt++.
  - SCLK fall: tx shifter shifts left by one.
  - Byte complete = rise with bit_cnt == 7. The byte is delivered to RX; the next SCLK fall reloads the tx shifter instead of shifting.
  - Synchronized SS_n rising: go to IDLE. A partial rx byte is discarded. tx_holding is untouched unless it was already consumed.
- **Tx shifter load.**
  - If tx_primed: shifter <= tx_holding, tx_primed <= 0.
  - Otherwise: shifter <= 0x00, TUR <= 1.
- MISO = tx shifter[7].
- **RX (FIFO not compiled in).**
  - Byte complete: rx_holding <= byte, RRDY <= 1.
  - If RRDY was already 1: ROE <= 1 and the new byte overwrites the old one.
  - rxdata read clears RRDY.
- **Flag clearing.** A status write clears ROE, TOE and TUR. It does not clear RRDY.
- **Simultaneous events.**
  - Tx shifter load and txdata write in the same cycle: the write is judged against the pre-load TRDY, so it is rejected when tx_primed was 1.
  - Byte complete and rxdata read in the same cycle: RRDY ends at 1 and ROE is not set.
- **Reset mid-transfer.** Every register returns to its reset value and the FSM returns to IDLE. The master's in-flight byte is lost.

## Timing
- **Reset values:**
  - data_to_cpu = 0, irq = 0, MISO = 0
  - MISO_oe follows SS_n
  - all flags 0, TRDY = 1, control = 0
- **Read latency.** data_to_cpu is valid one clk after rd_strobe; read is a two-cycle access.
- **Write latency.** Writes take effect on the clk after wr_strobe.
- **Pin-to-detect latency.** 3 clk from an SCLK or SS_n pin edge to internal edge detection.
- **MISO update.** MISO changes ≤ 4 clk after a SCLK pin fall.
- **SCLK constraint.** SCLK high and low times must each be ≥ 4 clk, i.e. SCLK ≤ clk/8 (6.25 MHz).
- **SS_n setup.** SS_n low to first SCLK rise ≥ 4 clk, so the first bit is on MISO in time.
- **RRDY/irq latency.** RRDY is visible 4 clk after the 8th SCLK pin rise; irq follows 1 clk later.

## Configuration
- **SPIS_RX_FIFO_EN defined:**
  - rx_holding is replaced by an RX_FIFO_DEPTH × 8 FIFO.
  - RRDY = FIFO not empty.
  - Each rxdata read pops one entry.
  - Byte complete while the FIFO is full: byte dropped, ROE <= 1.
  - status[14:12] = fill level (saturates at 7).
- **SPIS_RX_FIFO_EN undefined:** single holding register with overwrite-on-overrun; status[14:12] = 0.

## Structure
- **Package final_soc_spis_pkg:**
  - register address constants
  - status and control bit indices
  - DATABITS = 8
  - FSM state enum {IDLE, ACTIVE}
- **Sub-module final_soc_spis_sync:** 2-flop synchronizer with asynchronous reset, instantiated 3 times. SS_n resets to 1; SCLK and MOSI reset to 0.

## Test plan
- **Reset:** pulse reset_n → status reads 0x0040, irq = 0, MISO_oe = 0.
- **Full-duplex byte:** write txdata 0xA5; master sends 0x3C at clk/8 → MISO bits 1,0,1,0,0,1,0,1; rxdata reads 0x3C; RRDY clears after the read; TRDY reads 1.
- **Underrun:** no txdata written, control = 0x0020, one transfer → MISO all 0, status bits TUR and E set, irq = 1; status write → irq = 0.
- **Overrun:** two received bytes 0x11 then 0x22 without an rxdata read → ROE = 1 and rxdata = 0x22. With SPIS_RX_FIFO_EN, 5 bytes into depth 4 → ROE = 1, reads return 4 bytes in order, 5th dropped.
- **Aborted frame:** SS_n rises after 4 SCLK cycles → RRDY stays 0; next complete 0x5A frame reads back 0x5A.
- **TX overflow:** write txdata 0x81 then 0x42 with no transfer → TOE = 1; next transfer transmits 0x81.
